// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and default sizes for the LC-3 memory controller.
//   mem_state_t : controller FSM encoding
//   WAIT_CNT_W  : width of the wait-state counter (WAIT_STATES 0..15)
//   DEF_*       : default DATA_W / ADDR_W / DEPTH
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_DONE
  } mem_state_t;

  localparam int unsigned WAIT_CNT_W = 4;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DEPTH  = 256;

endpackage

// File: rtl/lc3_mem_array.sv
// lc3_mem_array: DEPTH x DATA_W word storage, all ones at time zero.
// Synchronous write, combinational read from the address.
// Optional macro LC3_MEM_PARITY_EN adds one even-parity bit per word,
// computed on write and checked on read.
// Ports:
//   clk         rising-edge clock
//   i_we        write enable
//   i_addr      word index
//   i_wdata     write data
//   o_rdata_c   combinational read data at i_addr
//   o_par_err_c combinational parity mismatch at i_addr (0 without parity)
module lc3_mem_array
  import lc3_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata_c,
  output logic              o_par_err_c
);

`ifdef LC3_MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
  // Parity column of the power-up image is consistent with all-ones data.
  localparam logic [MEM_W-1:0] MEM_INIT = {1'(DATA_W % 2), {DATA_W{1'b1}}};

  logic [MEM_W-1:0] r_mem [DEPTH] = '{default: MEM_INIT};
  logic [MEM_W-1:0] w_word;

  // Store data with its even-parity bit on top.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= {^i_wdata, i_wdata};
    end
  end

  assign w_word      = r_mem[i_addr];
  assign o_rdata_c   = w_word[DATA_W-1:0];
  assign o_par_err_c = w_word[DATA_W] ^ (^w_word[DATA_W-1:0]);
`else
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '1};

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata_c   = r_mem[i_addr];
  assign o_par_err_c = 1'b0;
`endif

endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 main memory with MEM.EN / R handshake and programmable
// wait states. A request accepted in IDLE is committed at the edge that
// enters DONE; memRdy/memErr pulse for the single DONE cycle.
// Addresses >= DEPTH are flagged on memErr instead of aliasing.
// Optional macro LC3_MEM_PARITY_EN: per-word even parity, read mismatch
// also raises memErr.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   memEn   request strobe (sampled in IDLE only)
//   memWE   1 = write, 0 = read
//   MARReg  word address
//   mdrOut  write data
//   memOut  registered read data, held until the next read completes
//   memRdy  one-cycle completion pulse
//   memErr  one-cycle error pulse, only with memRdy
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memEn,
  input  logic              memWE,
  input  logic [ADDR_W-1:0] MARReg,
  input  logic [DATA_W-1:0] mdrOut,
  output logic [DATA_W-1:0] memOut,
  output logic              memRdy,
  output logic              memErr
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  mem_state_t              r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                    r_we, w_we_nxt;
  logic [ADDR_W-1:0]       r_addr, w_addr_nxt;
  logic [DATA_W-1:0]       r_data, w_data_nxt;
  logic [DATA_W-1:0]       r_out, w_out_nxt;
  logic                    r_rdy, w_rdy_nxt;
  logic                    r_err, w_err_nxt;

  logic                    w_acc_we;
  logic [ADDR_W-1:0]       w_acc_addr;
  logic [DATA_W-1:0]       w_acc_data;
  logic                    w_in_range;
  logic                    w_commit;
  logic                    w_arr_we;
  logic [DATA_W-1:0]       w_rd_data;
  logic                    w_par_err;

  // With zero wait states the commit edge is the accepting edge, so the
  // access fields come straight from the ports while IDLE.
  assign w_acc_we   = (r_state == MEM_IDLE) ? memWE  : r_we;
  assign w_acc_addr = (r_state == MEM_IDLE) ? MARReg : r_addr;
  assign w_acc_data = (r_state == MEM_IDLE) ? mdrOut : r_data;

  // Full-width compare; one extra bit so DEPTH == 2**ADDR_W is representable.
  assign w_in_range = ({1'b0, w_acc_addr} < DEPTH_EXT);

  // Gated by reset so nothing is written while reset is held.
  assign w_arr_we = w_commit & w_acc_we & w_in_range & reset;

  lc3_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk         (clk),
    .i_we        (w_arr_we),
    .i_addr      (w_acc_addr[IDX_W-1:0]),
    .i_wdata     (w_acc_data),
    .o_rdata_c   (w_rd_data),
    .o_par_err_c (w_par_err)
  );

  // Next-state, counter, request latches and commit-cycle outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_out_nxt   = r_out;
    w_rdy_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_commit    = 1'b0;

    case (r_state)
      MEM_IDLE: begin
        if (memEn) begin
          w_we_nxt   = memWE;
          w_addr_nxt = MARReg;
          w_data_nxt = mdrOut;
          if (WAIT_STATES == 0) begin
            w_state_nxt = MEM_DONE;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = MEM_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      MEM_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = MEM_DONE;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
        end
      end
      MEM_DONE: begin
        w_state_nxt = MEM_IDLE;
      end
      default: begin
        w_state_nxt = MEM_IDLE;
      end
    endcase

    if (w_commit) begin
      w_rdy_nxt = 1'b1;
      w_err_nxt = ~w_in_range | (w_in_range & ~w_acc_we & w_par_err);
      if (!w_acc_we) begin
        w_out_nxt = w_in_range ? w_rd_data : '1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MEM_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_out   <= '1;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_out   <= w_out_nxt;
      r_rdy   <= w_rdy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign memOut = r_out;
  assign memRdy = r_rdy;
  assign memErr = r_err;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: scoreboard bench for lc3_mem_ctrl. Two instances share
// clock and reset: u_dut_a with WAIT_STATES=0, u_dut_b with WAIT_STATES=3.
// With LC3_MEM_PARITY_EN defined, a parity-corruption scenario is added.
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;

  logic        en_a, we_a, rdy_a, err_a;
  logic [15:0] addr_a, wdat_a, out_a;
  logic        en_b, we_b, rdy_b, err_b;
  logic [15:0] addr_b, wdat_b, out_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] m_a [256];
  logic [15:0] m_b [256];
  logic [15:0] o_a, o_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) u_dut_a (
    .clk(clk), .reset(reset), .memEn(en_a), .memWE(we_a), .MARReg(addr_a),
    .mdrOut(wdat_a), .memOut(out_a), .memRdy(rdy_a), .memErr(err_a)
  );

  lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(3)) u_dut_b (
    .clk(clk), .reset(reset), .memEn(en_b), .memWE(we_b), .MARReg(addr_b),
    .mdrOut(wdat_b), .memOut(out_b), .memRdy(rdy_b), .memErr(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every memRdy pulse must match the oldest pending request.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rdy_a) begin
      if (q_a.size() == 0) chk("a_spurious_rdy", 32'(rdy_a), 32'(0));
      else begin
        e = q_a.pop_front();
        chk("a_latency", 32'(cyc), 32'(e.due));
        chk("a_data", 32'(out_a), 32'(e.data));
        chk("a_err", 32'(err_a), 32'(e.err));
      end
    end else if (err_a) chk("a_err_without_rdy", 32'(err_a), 32'(0));
    if (rdy_b) begin
      if (q_b.size() == 0) chk("b_spurious_rdy", 32'(rdy_b), 32'(0));
      else begin
        e = q_b.pop_front();
        chk("b_latency", 32'(cyc), 32'(e.due));
        chk("b_data", 32'(out_b), 32'(e.data));
        chk("b_err", 32'(err_b), 32'(e.err));
      end
    end else if (err_b) chk("b_err_without_rdy", 32'(err_b), 32'(0));
  end

  // One request, entered and left on a falling edge. poke pulses memEn
  // during the wait states with a different write that must be ignored.
  task automatic access(input bit b, input bit w, input logic [15:0] ad,
                        input logic [15:0] dt, input bit perr, input bit poke);
    exp_t e;
    bit   inr;
    int   ws;
    inr   = (ad < 16'd256);
    ws    = b ? 3 : 0;
    e.due = cyc + 1 + ws;
    e.err = !inr || perr;
    if (!b) begin
      if (w) begin
        if (inr) m_a[ad[7:0]] = dt;
      end else o_a = inr ? m_a[ad[7:0]] : 16'hFFFF;
      e.data = o_a;
      q_a.push_back(e);
      en_a = 1'b1; we_a = w; addr_a = ad; wdat_a = dt;
    end else begin
      if (w) begin
        if (inr) m_b[ad[7:0]] = dt;
      end else o_b = inr ? m_b[ad[7:0]] : 16'hFFFF;
      e.data = o_b;
      q_b.push_back(e);
      en_b = 1'b1; we_b = w; addr_b = ad; wdat_b = dt;
    end
    @(posedge clk);
    #1;
    // Scramble the request inputs: latched values must be used.
    en_a = 1'b0; we_a = ~we_a; addr_a = ~addr_a; wdat_a = ~wdat_a;
    en_b = 1'b0; we_b = ~we_b; addr_b = ~addr_b; wdat_b = ~wdat_b;
    if (poke && ws >= 2) begin
      @(negedge clk);
      en_b = 1'b1; we_b = 1'b1; addr_b = 16'h0020; wdat_b = 16'h5555;
      @(negedge clk);
      en_b = 1'b0;
      repeat (ws) @(negedge clk);
    end else begin
      repeat (ws + 2) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    en_a = 1'b0; we_a = 1'b0; addr_a = '0; wdat_a = '0;
    en_b = 1'b0; we_b = 1'b0; addr_b = '0; wdat_b = '0;
    for (int i = 0; i < 256; i++) begin
      m_a[i] = 16'hFFFF;
      m_b[i] = 16'hFFFF;
    end
    o_a = 16'hFFFF;
    o_b = 16'hFFFF;

    repeat (3) @(negedge clk);
    chk("rst_out_a", 32'(out_a), 32'hFFFF);
    chk("rst_rdy_a", 32'(rdy_a), 32'(0));
    chk("rst_err_a", 32'(err_a), 32'(0));
    chk("rst_out_b", 32'(out_b), 32'hFFFF);
    chk("rst_rdy_b", 32'(rdy_b), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    // Basic read, write then read back, zero wait states.
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 1'b1, 16'h0042, 16'h1234, 1'b0, 1'b0);
    access(1'b0, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0);

    // Three wait states, including an ignored strobe while waiting.
    access(1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0);
    access(1'b1, 1'b1, 16'h0011, 16'h9876, 1'b0, 1'b0);
    access(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b1);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);

    // Range boundary and full-width address compare.
    access(1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b0);
    access(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 1'b1, 16'h1000, 16'hCAFE, 1'b0, 1'b0);
    access(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 1'b1, 16'h00FF, 16'h7777, 1'b0, 1'b0);
    access(1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);

    // Reset during WAIT aborts the write and suppresses memRdy.
    en_b = 1'b1; we_b = 1'b1; addr_b = 16'h0005; wdat_b = 16'hAAAA;
    @(posedge clk);
    #1 en_b = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_rdy_b", 32'(rdy_b), 32'(0));
    repeat (2) @(negedge clk);
    chk("abort_out_b", 32'(out_b), 32'hFFFF);
    chk("abort_out_a", 32'(out_a), 32'hFFFF);
    reset = 1'b1;
    o_a = 16'hFFFF;
    o_b = 16'hFFFF;
    repeat (6) @(negedge clk);
    access(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0);

    // Mixed traffic on both instances.
    for (int i = 0; i < 12; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, 16'h01FF)), 16'($urandom), 1'b0, 1'b0);
    end

`ifdef LC3_MEM_PARITY_EN
    access(1'b0, 1'b1, 16'h0007, 16'h0001, 1'b0, 1'b0);
    u_dut_a.u_array.r_mem[7][16] = ~u_dut_a.u_array.r_mem[7][16];
    access(1'b0, 1'b0, 16'h0007, 16'h0000, 1'b1, 1'b0);
    access(1'b0, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("a_drain", 32'(q_a.size()), 32'(0));
    chk("b_drain", 32'(q_b.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
